hazard_unit: RTL and testbench

Parametrised hazard and bypass controller for the in-order RISC-V pipeline. It replaces the fixed exe/mem/wb stall tracking inside the control path with a configurable-depth scoreboard of in-flight destination registers. It produces `hazard_stall`, a decode-issue strobe and per-operand bypass selects for the datapath. It sits between the decoder (control signals and register addresses) and the datapath operand muxes, and it honours the global cache-miss freeze.

---
 rtl/hazard_unit.sv | 191 +++++++++++++++++++
 tb/tb_hazard_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard and bypass controller for the in-order pipeline. A DEPTH-deep
// scoreboard records the destination register of every instruction in flight
// after decode. Each new decode instruction is compared against it. The
// results are a decode stall, an issue strobe, per-operand bypass selects and
// an occupancy count.
//
// Parameters:
//   NREG_BITS - register address width
//   DEPTH     - tracked stages after decode (stage 1 = exe), 2..8
//   LOAD_LAT  - stages in which a load result cannot yet be bypassed
//   BYPASS    - 1: full forwarding, 0: stall on every RAW
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   dec_*                 - decode-stage instruction fields and kill
//   cmiss_stall           - cache-miss freeze, holds every entry
//   hazard_stall          - decode must hold its instruction
//   issue                 - decode instruction enters stage 1 at next edge
//   rs1_byp, rs2_byp      - 0 = register file, k = result of stage k
//   occupancy             - number of valid in-flight entries
module hazard_unit #(
  parameter int NREG_BITS = 5,
  parameter int DEPTH     = 3,
  parameter int LOAD_LAT  = 1,
  parameter int BYPASS    = 1,
  localparam int SELW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [NREG_BITS-1:0] dec_rs1_addr,
  input  logic [NREG_BITS-1:0] dec_rs2_addr,
  input  logic                 dec_rs1_oen,
  input  logic                 dec_rs2_oen,
  input  logic [NREG_BITS-1:0] dec_wb_addr,
  input  logic                 dec_rf_wen,
  input  logic                 dec_is_load,
  input  logic                 dec_is_csr,
  input  logic                 dec_kill,
  input  logic                 cmiss_stall,
  output logic                 hazard_stall,
  output logic                 issue,
  output logic [SELW-1:0]      rs1_byp,
  output logic [SELW-1:0]      rs2_byp,
  output logic [SELW-1:0]      occupancy
);

  // Scoreboard entries, index k = pipeline stage k.
  logic [DEPTH:1]         valid_q, valid_d;
  logic [DEPTH:1]         rf_wen_q, rf_wen_d;
  logic [DEPTH:1]         is_load_q, is_load_d;
  logic [DEPTH:1]         is_csr_q, is_csr_d;
  logic [NREG_BITS-1:0]   wbaddr_q [1:DEPTH];
  logic [NREG_BITS-1:0]   wbaddr_d [1:DEPTH];

  logic [DEPTH:1]         match1_s, match2_s;
  logic                   cond_s;
  logic [SELW-1:0]        sel1_s, sel2_s;
  logic [SELW-1:0]        occ_s;

  // Per-stage RAW match; x0 and disabled operands never match.
  always_comb begin
    match1_s = '0;
    match2_s = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      match1_s[k] = valid_q[k] & rf_wen_q[k] & (wbaddr_q[k] == dec_rs1_addr) &
                    (dec_rs1_addr != '0) & dec_rs1_oen;
      match2_s[k] = valid_q[k] & rf_wen_q[k] & (wbaddr_q[k] == dec_rs2_addr) &
                    (dec_rs2_addr != '0) & dec_rs2_oen;
    end
  end

  // Hazard condition: unbypassable loads (or any RAW without forwarding),
  // plus CSR serialisation while the CSR sits in stage 1.
  always_comb begin
    cond_s = valid_q[1] & is_csr_q[1];
    for (int k = 1; k <= DEPTH; k++) begin
      if (BYPASS != 0) begin
        if (k <= LOAD_LAT) begin
          cond_s = cond_s | ((match1_s[k] | match2_s[k]) & is_load_q[k]);
        end else begin
          cond_s = cond_s;
        end
      end else begin
        cond_s = cond_s | match1_s[k] | match2_s[k];
      end
    end
  end

  // Bypass selects. Scanning from the oldest stage towards stage 1 lets the
  // youngest producer overwrite older ones.
  always_comb begin
    sel1_s = '0;
    sel2_s = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match1_s[k]) begin
        sel1_s = SELW'(k);
      end else begin
        sel1_s = sel1_s;
      end
      if (match2_s[k]) begin
        sel2_s = SELW'(k);
      end else begin
        sel2_s = sel2_s;
      end
    end
  end

  // Popcount of valid entries.
  always_comb begin
    occ_s = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      occ_s = occ_s + SELW'(valid_q[k]);
    end
  end

  // Output decode. While reset is high the entries may still hold stale
  // contents until the edge, so stall, selects and occupancy are masked.
  always_comb begin
    hazard_stall = ~reset & cond_s & dec_valid & ~dec_kill;
    issue        = dec_valid & ~dec_kill & ~hazard_stall & ~cmiss_stall;
    if ((BYPASS != 0) && !reset) begin
      rs1_byp = sel1_s;
      rs2_byp = sel2_s;
    end else begin
      rs1_byp = '0;
      rs2_byp = '0;
    end
    if (!reset) begin
      occupancy = occ_s;
    end else begin
      occupancy = '0;
    end
  end

  // Next entry state: shift by one stage unless frozen by a cache miss;
  // stage 1 takes the decode instruction on issue, otherwise a bubble.
  always_comb begin
    valid_d   = valid_q;
    rf_wen_d  = rf_wen_q;
    is_load_d = is_load_q;
    is_csr_d  = is_csr_q;
    wbaddr_d  = wbaddr_q;
    if (!cmiss_stall) begin
      for (int k = DEPTH; k >= 2; k--) begin
        valid_d[k]   = valid_q[k-1];
        rf_wen_d[k]  = rf_wen_q[k-1];
        is_load_d[k] = is_load_q[k-1];
        is_csr_d[k]  = is_csr_q[k-1];
        wbaddr_d[k]  = wbaddr_q[k-1];
      end
      if (issue) begin
        valid_d[1]   = 1'b1;
        rf_wen_d[1]  = dec_rf_wen;
        is_load_d[1] = dec_is_load;
        is_csr_d[1]  = dec_is_csr;
        wbaddr_d[1]  = dec_wb_addr;
      end else begin
        valid_d[1]   = 1'b0;
        rf_wen_d[1]  = 1'b0;
        is_load_d[1] = 1'b0;
        is_csr_d[1]  = 1'b0;
        wbaddr_d[1]  = '0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry registers; reset drops every entry even during a cache miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      rf_wen_q  <= '0;
      is_load_q <= '0;
      is_csr_q  <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        wbaddr_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      rf_wen_q  <= rf_wen_d;
      is_load_q <= is_load_d;
      is_csr_q  <= is_csr_d;
      for (int k = 1; k <= DEPTH; k++) begin
        wbaddr_q[k] <= wbaddr_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three configurations driven with the same stimulus.
// Each one is checked every cycle against a model that keeps a list of
// in-flight instructions tagged with their age. Short directed sequences pin
// the model with literal expectations.
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, dec_valid, rs1_oen, rs2_oen, rf_wen, is_load, is_csr, kill, cmiss;
  logic [4:0] rs1, rs2, wb;

  logic       st_a, iss_a, st_b, iss_b, st_c, iss_c;
  logic [1:0] b1_a, b2_a, occ_a;
  logic [2:0] b1_b, b2_b, occ_b, b1_c, b2_c, occ_c;

  hazard_unit dut_a (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1_addr(rs1), .dec_rs2_addr(rs2),
    .dec_rs1_oen(rs1_oen), .dec_rs2_oen(rs2_oen), .dec_wb_addr(wb), .dec_rf_wen(rf_wen),
    .dec_is_load(is_load), .dec_is_csr(is_csr), .dec_kill(kill), .cmiss_stall(cmiss),
    .hazard_stall(st_a), .issue(iss_a), .rs1_byp(b1_a), .rs2_byp(b2_a), .occupancy(occ_a));

  hazard_unit #(.DEPTH(4), .LOAD_LAT(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1_addr(rs1), .dec_rs2_addr(rs2),
    .dec_rs1_oen(rs1_oen), .dec_rs2_oen(rs2_oen), .dec_wb_addr(wb), .dec_rf_wen(rf_wen),
    .dec_is_load(is_load), .dec_is_csr(is_csr), .dec_kill(kill), .cmiss_stall(cmiss),
    .hazard_stall(st_b), .issue(iss_b), .rs1_byp(b1_b), .rs2_byp(b2_b), .occupancy(occ_b));

  hazard_unit #(.DEPTH(5), .LOAD_LAT(2), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1_addr(rs1), .dec_rs2_addr(rs2),
    .dec_rs1_oen(rs1_oen), .dec_rs2_oen(rs2_oen), .dec_wb_addr(wb), .dec_rf_wen(rf_wen),
    .dec_is_load(is_load), .dec_is_csr(is_csr), .dec_kill(kill), .cmiss_stall(cmiss),
    .hazard_stall(st_c), .issue(iss_c), .rs1_byp(b1_c), .rs2_byp(b2_c), .occupancy(occ_c));

  logic       st_o [3];
  logic       iss_o [3];
  logic [3:0] b1_o [3];
  logic [3:0] b2_o [3];
  logic [3:0] occ_o [3];
  assign st_o[0] = st_a;   assign st_o[1] = st_b;   assign st_o[2] = st_c;
  assign iss_o[0] = iss_a; assign iss_o[1] = iss_b; assign iss_o[2] = iss_c;
  assign b1_o[0] = {2'b00, b1_a}; assign b1_o[1] = {1'b0, b1_b}; assign b1_o[2] = {1'b0, b1_c};
  assign b2_o[0] = {2'b00, b2_a}; assign b2_o[1] = {1'b0, b2_b}; assign b2_o[2] = {1'b0, b2_c};
  assign occ_o[0] = {2'b00, occ_a}; assign occ_o[1] = {1'b0, occ_b}; assign occ_o[2] = {1'b0, occ_c};

  int cfg_depth [3] = '{3, 4, 5};
  int cfg_ll    [3] = '{1, 1, 2};
  int cfg_byp   [3] = '{1, 0, 1};

  // Model: list of in-flight instructions (no bubbles) with their age.
  typedef struct {
    int         age;
    logic [4:0] wb;
    bit         wen;
    bit         load;
    bit         csr;
  } rec_t;
  rec_t fl [3][8];
  int   cnt [3] = '{0, 0, 0};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_eval(input int i, output bit st, output bit iss,
                                     output int y1, output int y2, output int occ);
    bit cond;
    int m1, m2;
    cond = 1'b0;
    m1 = 0;
    m2 = 0;
    for (int e = 0; e < cnt[i]; e++) begin
      if (fl[i][e].csr && fl[i][e].age == 1) cond = 1'b1;
      if (fl[i][e].wen && fl[i][e].wb == rs1 && rs1 != 5'd0 && rs1_oen) begin
        if (cfg_byp[i] == 0 || (fl[i][e].load && fl[i][e].age <= cfg_ll[i])) cond = 1'b1;
        if (m1 == 0 || fl[i][e].age < m1) m1 = fl[i][e].age;
      end
      if (fl[i][e].wen && fl[i][e].wb == rs2 && rs2 != 5'd0 && rs2_oen) begin
        if (cfg_byp[i] == 0 || (fl[i][e].load && fl[i][e].age <= cfg_ll[i])) cond = 1'b1;
        if (m2 == 0 || fl[i][e].age < m2) m2 = fl[i][e].age;
      end
    end
    if (reset) begin
      st = 1'b0; occ = 0; y1 = 0; y2 = 0;
    end else begin
      st = cond && dec_valid && !kill;
      occ = cnt[i];
      y1 = (cfg_byp[i] != 0) ? m1 : 0;
      y2 = (cfg_byp[i] != 0) ? m2 : 0;
    end
    iss = dec_valid && !kill && !st && !cmiss;
  endfunction

  function automatic void model_step(input int i, input bit iss);
    int n;
    if (reset) begin
      cnt[i] = 0;
    end else if (!cmiss) begin
      n = 0;
      for (int e = 0; e < cnt[i]; e++) begin
        if (fl[i][e].age < cfg_depth[i]) begin
          fl[i][n] = fl[i][e];
          fl[i][n].age = fl[i][e].age + 1;
          n++;
        end
      end
      if (iss) begin
        fl[i][n].age = 1; fl[i][n].wb = wb; fl[i][n].wen = rf_wen;
        fl[i][n].load = is_load; fl[i][n].csr = is_csr;
        n++;
      end
      cnt[i] = n;
    end
  endfunction

  // Model advance on the active edge, using the inputs of the ending cycle.
  always @(posedge clk) begin
    bit s, is;
    int y1, y2, oc;
    for (int i = 0; i < 3; i++) begin
      model_eval(i, s, is, y1, y2, oc);
      model_step(i, is);
    end
  end

  // Per-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    bit s, is;
    int y1, y2, oc;
    for (int i = 0; i < 3; i++) begin
      model_eval(i, s, is, y1, y2, oc);
      chk($sformatf("stall[%0d]", i), st_o[i], s);
      chk($sformatf("issue[%0d]", i), iss_o[i], is);
      chk($sformatf("occ[%0d]", i), occ_o[i], oc);
      if (is || reset) begin
        chk($sformatf("rs1_byp[%0d]", i), b1_o[i], y1);
        chk($sformatf("rs2_byp[%0d]", i), b2_o[i], y2);
      end
    end
  end

  task automatic idle();
    dec_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rs1_oen = 1'b0; rs2_oen = 1'b0;
    wb = 5'd0; rf_wen = 1'b0; is_load = 1'b0; is_csr = 1'b0; kill = 1'b0; cmiss = 1'b0;
  endtask

  task automatic dec(input logic [4:0] a1, input bit e1, input logic [4:0] a2, input bit e2,
                     input logic [4:0] w, input bit we, input bit ld, input bit cs);
    dec_valid = 1'b1; rs1 = a1; rs1_oen = e1; rs2 = a2; rs2_oen = e2;
    wb = w; rf_wen = we; is_load = ld; is_csr = cs; kill = 1'b0; cmiss = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    repeat (6) begin
      tick();
      idle();
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    #1 chk("rst_occ", occ_a, 0); chk("rst_stall", st_a, 0);
    tick(); reset = 1'b0; idle();
    #1 chk("post_rst_occ", occ_a, 0); chk("post_rst_byp", b1_a, 0);

    // load-use: lw x5 then add x6,x5,x1
    tick(); dec(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1 chk("lw_issue", iss_a, 1);
    tick(); dec(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_stall", st_a, 1); chk("lu_noissue", iss_a, 0); chk("lu_c_stall1", st_c, 1);
    tick();
    #1 chk("lu_stall_clear", st_a, 0); chk("lu_issue", iss_a, 1);
    chk("lu_byp1", b1_a, 2); chk("lu_byp2", b2_a, 0); chk("lu_c_stall2", st_c, 1);
    tick();
    #1 chk("lu_c_issue", iss_c, 1); chk("lu_c_byp", b1_c, 3);

    // youngest producer wins
    flush();
    tick(); dec(5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick(); dec(5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick(); dec(5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    #1 chk("yp_stall", st_a, 0); chk("yp_issue", iss_a, 1);
    chk("yp_byp1", b1_a, 1); chk("yp_byp2", b2_a, 1);

    // no-bypass instance: addi x7 then or x8,x7,x0
    flush();
    tick(); dec(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    #1 chk("nb_issue0", iss_b, 1);
    tick(); dec(5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1 chk("nb_stall", st_b, 1);
    repeat (3) begin
      tick();
      #1 chk("nb_stall", st_b, 1);
    end
    tick();
    #1 chk("nb_issue", iss_b, 1); chk("nb_byp1", b1_b, 0); chk("nb_byp2", b2_b, 0);
    flush();
    tick(); dec(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick(); dec(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1 chk("x0_nostall", st_b, 0); chk("x0_issue", iss_b, 1);

    // CSR followed by a three-cycle cache miss
    flush();
    tick(); dec(5'd11, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
    #1 chk("csr_issue", iss_a, 1);
    tick(); dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0); cmiss = 1'b1;
    #1 chk("csr_miss_stall", st_a, 1); chk("csr_miss_occ", occ_a, 1); chk("csr_miss_iss", iss_a, 0);
    repeat (2) begin
      tick();
      #1 chk("csr_miss_stall", st_a, 1); chk("csr_miss_occ", occ_a, 1); chk("csr_miss_iss", iss_a, 0);
    end
    tick(); cmiss = 1'b0;
    #1 chk("csr_stall_last", st_a, 1);
    tick();
    #1 chk("csr_follow_issue", iss_a, 1); chk("csr_follow_nostall", st_a, 0);

    // kill during a load-use match
    flush();
    tick(); dec(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick(); dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0); kill = 1'b1;
    #1 chk("kill_stall", st_a, 0); chk("kill_issue", iss_a, 0);
    tick(); idle();
    #1 chk("kill_bubble_occ", occ_a, 1);

    // reset with three entries in flight, during a miss
    flush();
    for (int j = 0; j < 3; j++) begin
      tick(); dec(5'd0, 1'b1, 5'd0, 1'b0, 5'(20 + j), 1'b1, 1'b0, 1'b0);
    end
    tick(); idle();
    #1 chk("pre_rst_occ", occ_a, 3);
    tick(); reset = 1'b1; cmiss = 1'b1;
    #1 chk("mid_rst_occ", occ_a, 0);
    tick(); reset = 1'b0; cmiss = 1'b0;
    #1 chk("after_rst_occ", occ_a, 0); chk("after_rst_occ_b", occ_b, 0);

    // random traffic over a small register set to force frequent hazards
    repeat (3000) begin
      tick();
      dec_valid = ($urandom_range(0, 9) < 7);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      wb      = 5'($urandom_range(0, 3));
      rs1_oen = ($urandom_range(0, 3) != 0);
      rs2_oen = ($urandom_range(0, 1) != 0);
      rf_wen  = ($urandom_range(0, 3) != 0);
      is_load = ($urandom_range(0, 2) == 0);
      is_csr  = ($urandom_range(0, 15) == 0);
      kill    = ($urandom_range(0, 9) == 0);
      cmiss   = ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 99) == 0);
    end
    tick(); idle(); reset = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
